// File: rtl/input_manager_pkg.sv
// Shared constants for the input manager: repeat timing defaults, counter
// width, repeat-channel state encoding and a small edge-detect helper.
package input_manager_pkg;

    localparam int unsigned DAS_DELAY_DEF  = 32'd16;
    localparam int unsigned DAS_SPEED_DEF  = 32'd6;
    localparam int unsigned DOWN_SPEED_DEF = 32'd2;

    // Wide enough to hold DAS_DELAY; counters reload before reaching the top.
    localparam int unsigned CNT_W = 32'd5;

    typedef logic [CNT_W-1:0] cnt_t;

    // Repeat-channel phases.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Rising-edge detect for the one-shot key group.
    function automatic logic [3:0] rise_edge4(input logic [3:0] lvl, input logic [3:0] prev);
        return lvl & ~prev;
    endfunction

endpackage

// File: rtl/input_repeat_channel.sv
// One auto-repeating key channel: press-edge detect, immediate initial pulse,
// a delay phase counted in tick_game frames, then a periodic repeat phase.
// FIRE_AT_DELAY makes the tick that ends the delay phase emit a pulse too,
// which lets the soft-drop channel fire on tick 1 with DELAY = 1.
module input_repeat_channel
    import input_manager_pkg::*;
#(
    parameter int unsigned DELAY         = DAS_DELAY_DEF,
    parameter int unsigned SPEED         = DAS_SPEED_DEF,
    parameter bit          FIRE_AT_DELAY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic cmd
);

    localparam cnt_t DELAY_C = cnt_t'(DELAY);
    localparam cnt_t SPEED_C = cnt_t'(SPEED);

    logic       prev_q, prev_d;
    logic [1:0] st_q, st_d;
    cnt_t       cnt_q, cnt_d;
    logic       cmd_q, cmd_d;
    cnt_t       cnt_inc_s;

    assign cnt_inc_s = cnt_q + cnt_t'(1'b1);
    assign cmd       = cmd_q;

    // Next-state: release clears, press edge fires and restarts, ticks advance phases.
    always_comb begin
        prev_d = raw;
        st_d   = st_q;
        cnt_d  = cnt_q;
        cmd_d  = 1'b0;
        if (!raw) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
        end else if (!prev_q) begin
            // Press edge: the tick sampled in this cycle is deliberately ignored.
            cmd_d = 1'b1;
            cnt_d = '0;
            st_d  = ST_DELAY;
        end else if (tick) begin
            case (st_q)
                ST_DELAY: begin
                    if (cnt_inc_s == DELAY_C) begin
                        st_d  = ST_REPEAT;
                        cnt_d = '0;
                        cmd_d = FIRE_AT_DELAY;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_inc_s == SPEED_C) begin
                        cmd_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end
            endcase
        end else begin
            st_d  = st_q;
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            cmd_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            cmd_q  <= cmd_d;
        end
    end

endmodule

// File: rtl/input_manager.sv
// Input manager: turns clean key levels into registered one-cycle command
// pulses. Left/right auto-repeat (DAS); rotate/drop/hold are one-shots.
// Optional macro SOFT_DROP_REPEAT_EN: when defined, down auto-repeats on
// tick_game; otherwise down is a one-shot that ignores tick_game.
module input_manager
    import input_manager_pkg::*;
#(
    parameter int unsigned DAS_DELAY  = DAS_DELAY_DEF,
    parameter int unsigned DAS_SPEED  = DAS_SPEED_DEF,
    parameter int unsigned DOWN_SPEED = DOWN_SPEED_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_down,
    input  logic raw_rotate_cw,
    input  logic raw_rotate_ccw,
    input  logic raw_drop,
    input  logic raw_hold,
    output logic cmd_left,
    output logic cmd_right,
    output logic cmd_down,
    output logic cmd_rotate_cw,
    output logic cmd_rotate_ccw,
    output logic cmd_drop,
    output logic cmd_hold
);

    logic       down_tick_s;
    logic [3:0] os_raw_s;
    logic [3:0] os_prev_q, os_prev_d;
    logic [3:0] os_cmd_q, os_cmd_d;

`ifdef SOFT_DROP_REPEAT_EN
    assign down_tick_s = tick_game;
`else
    assign down_tick_s = 1'b0;
`endif

    input_repeat_channel #(
        .DELAY(DAS_DELAY), .SPEED(DAS_SPEED), .FIRE_AT_DELAY(1'b0)
    ) u_left (
        .clk(clk), .rst(rst), .raw(raw_left), .tick(tick_game), .cmd(cmd_left)
    );

    input_repeat_channel #(
        .DELAY(DAS_DELAY), .SPEED(DAS_SPEED), .FIRE_AT_DELAY(1'b0)
    ) u_right (
        .clk(clk), .rst(rst), .raw(raw_right), .tick(tick_game), .cmd(cmd_right)
    );

    // Down: delay of one frame that itself fires, then every DOWN_SPEED frames.
    input_repeat_channel #(
        .DELAY(32'd1), .SPEED(DOWN_SPEED), .FIRE_AT_DELAY(1'b1)
    ) u_down (
        .clk(clk), .rst(rst), .raw(raw_down), .tick(down_tick_s), .cmd(cmd_down)
    );

    assign os_raw_s = {raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw};

    // One-shot keys: pulse only on the sampled rising edge of the level.
    always_comb begin
        os_prev_d = os_raw_s;
        os_cmd_d  = rise_edge4(os_raw_s, os_prev_q);
    end

    // One-shot previous-level and command registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_prev_q <= 4'b0000;
            os_cmd_q  <= 4'b0000;
        end else begin
            os_prev_q <= os_prev_d;
            os_cmd_q  <= os_cmd_d;
        end
    end

    assign cmd_rotate_cw  = os_cmd_q[0];
    assign cmd_rotate_ccw = os_cmd_q[1];
    assign cmd_drop       = os_cmd_q[2];
    assign cmd_hold       = os_cmd_q[3];

endmodule

// File: tb/tb_input_manager.sv
// Self-checking bench for input_manager: a table of {keys, tick, expected}
// vectors plus hand-written DAS, soft-drop and reset sequences. Expected
// command vectors go through a scoreboard queue and are compared one clock
// after the stimulus is driven. Vector bit order:
// {hold, drop, rotate_ccw, rotate_cw, down, right, left}.
module tb_input_manager;

    localparam logic [6:0] K_NONE  = 7'b0000000;
    localparam logic [6:0] K_LEFT  = 7'b0000001;
    localparam logic [6:0] K_RIGHT = 7'b0000010;
    localparam logic [6:0] K_DOWN  = 7'b0000100;
    localparam logic [6:0] K_CW    = 7'b0001000;
    localparam logic [6:0] K_CCW   = 7'b0010000;
    localparam logic [6:0] K_DROP  = 7'b0100000;
    localparam logic [6:0] K_HOLD  = 7'b1000000;

    typedef struct {
        logic [6:0] keys;
        logic       tick;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic tick_game;
    logic [6:0] keys;
    logic cmd_left, cmd_right, cmd_down, cmd_rotate_cw, cmd_rotate_ccw, cmd_drop, cmd_hold;
    logic [6:0] cmd_v;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign cmd_v = {cmd_hold, cmd_drop, cmd_rotate_ccw, cmd_rotate_cw, cmd_down, cmd_right, cmd_left};

    input_manager dut (
        .clk(clk), .rst(rst), .tick_game(tick_game),
        .raw_left(keys[0]), .raw_right(keys[1]), .raw_down(keys[2]),
        .raw_rotate_cw(keys[3]), .raw_rotate_ccw(keys[4]), .raw_drop(keys[5]),
        .raw_hold(keys[6]),
        .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
        .cmd_rotate_cw(cmd_rotate_cw), .cmd_rotate_ccw(cmd_rotate_ccw),
        .cmd_drop(cmd_drop), .cmd_hold(cmd_hold)
    );

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: cmd got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, sample after the next rising edge.
    task automatic step(input logic [6:0] k, input logic t, input logic [6:0] exp, input string name);
        logic [6:0] e;
        keys      = k;
        tick_game = t;
        sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check(name, cmd_v, e);
    endtask

    function automatic void add(input logic [6:0] k, input logic t, input logic [6:0] e);
        vec_t v;
        v.keys = k;
        v.tick = t;
        v.exp  = e;
        tbl.push_back(v);
    endfunction

    function automatic logic soft_drop_en();
`ifdef SOFT_DROP_REPEAT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic [6:0] e;

        // ---- vector table ----
        // Rotate CW already held through reset: new press on first edge, then 11 quiet cycles.
        add(K_CW, 1'b0, K_CW);
        for (int i = 0; i < 11; i++) add(K_CW, 1'(i % 2), K_NONE);
        add(K_NONE, 1'b0, K_NONE);
        add(K_CCW, 1'b1, K_CCW);
        for (int i = 0; i < 11; i++) add(K_CCW, 1'(i % 2), K_NONE);
        add(K_NONE, 1'b0, K_NONE);
        add(K_DROP, 1'b0, K_DROP);
        for (int i = 0; i < 11; i++) add(K_DROP, 1'b1, K_NONE);
        add(K_NONE, 1'b0, K_NONE);
        // Hold: press, release, press again -> one pulse per press.
        add(K_HOLD, 1'b0, K_HOLD);
        add(K_HOLD, 1'b0, K_NONE);
        add(K_NONE, 1'b0, K_NONE);
        add(K_HOLD, 1'b0, K_HOLD);
        add(K_NONE, 1'b0, K_NONE);
        // Simultaneous left+right, and several one-shots together.
        add(K_LEFT | K_RIGHT, 1'b1, K_LEFT | K_RIGHT);
        add(K_LEFT | K_RIGHT, 1'b1, K_NONE);
        add(K_LEFT | K_RIGHT, 1'b1, K_NONE);
        add(K_NONE, 1'b1, K_NONE);
        add(K_CW | K_DROP | K_HOLD, 1'b0, K_CW | K_DROP | K_HOLD);
        add(K_CW | K_DROP | K_HOLD, 1'b0, K_NONE);
        add(K_NONE, 1'b0, K_NONE);

        // ---- reset state: cw held throughout reset ----
        rst       = 1'b0;
        tick_game = 1'b1;
        keys      = K_CW;
        repeat (3) @(negedge clk);
        check("reset_outputs", cmd_v, K_NONE);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].keys, tbl[i].tick, tbl[i].exp, $sformatf("table[%0d]", i));
        end

        // ---- left DAS: initial pulse, repeats on ticks 22, 28, 34, 40 ----
        step(K_LEFT, 1'b1, K_LEFT, "left_press");
        for (int t = 1; t <= 40; t++) begin
            e = (t >= 22 && ((t - 22) % 6) == 0) ? K_LEFT : K_NONE;
            step(K_LEFT, 1'b1, e, $sformatf("left_tick%0d", t));
            step(K_LEFT, 1'b0, K_NONE, $sformatf("left_gap%0d", t));
        end
        step(K_NONE, 1'b1, K_NONE, "left_release");

        // ---- right: 20 ticks, release, re-press: delay restarts ----
        step(K_RIGHT, 1'b0, K_RIGHT, "right_press");
        for (int t = 1; t <= 20; t++) step(K_RIGHT, 1'b1, K_NONE, $sformatf("right_tick%0d", t));
        step(K_NONE, 1'b1, K_NONE, "right_release");
        step(K_RIGHT, 1'b1, K_RIGHT, "right_repress");
        for (int t = 1; t <= 22; t++) begin
            e = (t == 22) ? K_RIGHT : K_NONE;
            step(K_RIGHT, 1'b1, e, $sformatf("right2_tick%0d", t));
        end
        step(K_NONE, 1'b0, K_NONE, "right2_release");

        // ---- down: soft-drop repeat on ticks 1,3,5 when enabled, one-shot otherwise ----
        step(K_DOWN, 1'b1, K_DOWN, "down_press");
        for (int t = 1; t <= 5; t++) begin
            e = (soft_drop_en() && (t % 2) == 1) ? K_DOWN : K_NONE;
            step(K_DOWN, 1'b1, e, $sformatf("down_tick%0d", t));
            step(K_DOWN, 1'b0, K_NONE, $sformatf("down_gap%0d", t));
        end
        step(K_NONE, 1'b0, K_NONE, "down_release");

        // ---- reset mid-repeat on left ----
        step(K_LEFT, 1'b0, K_LEFT, "rl_press");
        for (int t = 1; t <= 22; t++) begin
            e = (t == 22) ? K_LEFT : K_NONE;
            step(K_LEFT, 1'b1, e, $sformatf("rl_tick%0d", t));
        end
        // cmd_left is high right now; asynchronous reset must drop it at once.
        rst = 1'b0;
        #1;
        check("rst_async_clear", cmd_v, K_NONE);
        tick_game = 1'b1;
        @(negedge clk);
        check("rst_held_1", cmd_v, K_NONE);
        @(negedge clk);
        check("rst_held_2", cmd_v, K_NONE);
        rst = 1'b1;
        step(K_LEFT, 1'b0, K_LEFT, "rl_after_reset_press");
        for (int t = 1; t <= 6; t++) step(K_LEFT, 1'b1, K_NONE, $sformatf("rl2_tick%0d", t));
        step(K_NONE, 1'b0, K_NONE, "rl_release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
